// File: rtl/bcd_pkg.sv
// Shared BCD constants and types for both conversion directions.
//   state_t        : sequencing states of the BCD-to-binary converter
//   BCD_DIGIT_W    : bits per packed BCD digit
//   BCD_ADJ_THRESH : reverse double-dabble digit threshold (subtract 3 at/above)
//   BCD_ADD_THRESH : forward double-dabble digit threshold (add 3 at/above)
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int BCD_DIGIT_W    = 4;
    localparam int BCD_ADJ_THRESH = 8;
    localparam int BCD_ADD_THRESH = 5;

endpackage

// File: rtl/bcd_to_binary_if.sv
// Request/result handshake bundle for the BCD-to-binary converter.
//   in_valid/in_ready/bcd_in     : request side (packed BCD, digit 0 in [3:0])
//   out_valid/out_ready/bin_out/err : result side
// master: the requester/consumer; slave: the converter.
interface bcd_to_binary_if
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    logic                          in_valid;
    logic                          in_ready;
    logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in;
    logic                          out_valid;
    logic                          out_ready;
    logic [BIN_W-1:0]              bin_out;
    logic                          err;

    modport master (
        output in_valid, bcd_in, out_ready,
        input  in_ready, out_valid, bin_out, err
    );

    modport slave (
        input  in_valid, bcd_in, out_ready,
        output in_ready, out_valid, bin_out, err
    );

endinterface

// File: rtl/bcd_digit_adjust.sv
// One reverse double-dabble digit correction: after a right shift, a digit
// that is 8 or more subtracts 3.
//   din  : shifted BCD digit
//   dout : corrected digit
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    // Inputs here are at most 12, so the subtraction never wraps.
    assign dout = (din >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) ? din - BCD_DIGIT_W'(3) : din;

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential reverse double-dabble converter: packed BCD in, unsigned binary
// out, one bit per clock. Digits above 9 short-circuit to an error result.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave side of bcd_to_binary_if (request and result handshakes)
module bcd_to_binary
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
)(
    input  logic              clk,
    input  logic              rst,
    bcd_to_binary_if.slave    bus
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int R_W   = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t           state;
    logic [R_W-1:0]   work;
    logic [CNT_W-1:0] cnt;
    logic             err_q;

    logic [R_W-1:0]   shifted;
    logic [BCD_W-1:0] adj;

    function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(9)) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    assign shifted = work >> 1;

    // Correct each BCD digit of the already-shifted work register.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .din  (shifted[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            work  <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        cnt <= '0;
                        if (has_bad_digit(bus.bcd_in)) begin
                            work  <= '0;
                            err_q <= 1'b1;
                            state <= DONE;
                        end else begin
                            work  <= {bus.bcd_in, {BIN_W{1'b0}}};
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work <= {adj, shifted[BIN_W-1:0]};
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(BIN_W - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        err_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs come straight from the state register.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.bin_out   = work[BIN_W-1:0];
    assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
module tb_bcd_to_binary;
    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int R_W    = BCD_W + BIN_W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bcd_to_binary_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    bcd_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: decimal value of the digit string, or error if any digit > 9.
    function automatic bit ref_bad(input logic [BCD_W-1:0] b);
        bit bad = 0;
        for (int i = 0; i < DIGITS; i++) if (((b >> (4*i)) & 15) > 9) bad = 1;
        return bad;
    endfunction

    function automatic int ref_bin(input logic [BCD_W-1:0] b);
        int val = 0;
        int pw  = 1;
        if (ref_bad(b)) return 0;
        for (int i = 0; i < DIGITS; i++) begin
            val += int'((b >> (4*i)) & 15) * pw;
            pw  *= 10;
        end
        return val;
    endfunction

    function automatic logic [BCD_W-1:0] to_bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 1);
    endtask

    // One full request/result transaction with an optional result stall.
    task automatic convert(input logic [BCD_W-1:0] v, input int stall);
        int lat;
        bit bad;
        int expv;
        bad  = ref_bad(v);
        expv = ref_bin(v);
        wait_ready();
        bus.bcd_in    = v;
        bus.in_valid  = 1'b1;
        bus.out_ready = (stall == 0);
        tick();
        bus.in_valid = 1'b0;
        bus.bcd_in   = BCD_W'($urandom);
        check("in_ready_low", 32'(bus.in_ready), 0);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("latency", lat, bad ? 0 : BIN_W);
        check("bin_out", 32'(bus.bin_out), expv);
        check("err", 32'(bus.err), 32'(bad));
        check("bcd_part_zero", 32'(dut.work[R_W-1:BIN_W]), 0);
        for (int i = 0; i < stall; i++) begin
            if (i % 3 == 1) begin
                bus.in_valid = 1'b1;
                bus.bcd_in   = BCD_W'($urandom);
            end
            tick();
            bus.in_valid = 1'b0;
            check("stall_valid", 32'(bus.out_valid), 1);
            check("stall_bin", 32'(bus.bin_out), expv);
            check("stall_err", 32'(bus.err), 32'(bad));
            check("stall_in_ready", 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("post_in_ready", 32'(bus.in_ready), 1);
        check("post_out_valid", 32'(bus.out_valid), 0);
        check("post_err", 32'(bus.err), 0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.bcd_in    = '0;
        bus.out_ready = 1'b0;
        #2;
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_bin_out", 32'(bus.bin_out), 0);
        check("rst_err", 32'(bus.err), 0);
        tick();
        tick();
        rst = 1'b0;

        convert(12'h999, 0);
        convert(12'h000, 0);
        convert(12'h001, 0);
        convert(12'h255, 0);
        convert(12'h512, 0);
        convert(12'h1A3, 0);
        convert(12'h010, 0);
        convert(12'h437, 20);

        // Abort a conversion in its 5th shift cycle.
        wait_ready();
        bus.bcd_in   = 12'h888;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        #3 rst = 1'b1;
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 1);
        check("abort_out_valid", 32'(bus.out_valid), 0);
        check("abort_bin_out", 32'(bus.bin_out), 0);
        check("abort_err", 32'(bus.err), 0);
        tick();
        rst = 1'b0;
        convert(12'h123, 0);

        for (int i = 0; i < 1000; i++) convert(to_bcd(i), $urandom_range(0, 3));
        for (int i = 0; i < 100; i++) convert(BCD_W'($urandom), $urandom_range(0, 2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
